btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 500000, means the number of consecutive clk cycles the synchronized input must differ from btn_level before btn_level updates; legal range is >= 1.
REQ-002 Parameter CNT_W, default 8, is the width of press_count.
REQ-003 Port clk: input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 Port rst: input, 1 bit; synchronous, active-high reset.
REQ-005 Port btn_in: input, 1 bit, raw asynchronous, possibly bouncing, input.
REQ-006 Port btn_level: output, 1 bit, registered debounced level; this is the data input to the downstream dff stage.
REQ-007 Port rise_pulse: output, 1 bit, registered; high for one cycle on each debounced 0->1 transition.
REQ-008 Port fall_pulse: output, 1 bit, registered; high for one cycle on each debounced 1->0 transition.
REQ-009 Port press_count: output, CNT_W bits, registered count of debounced rising transitions.

Function
REQ-010 btn_in SHALL pass through a two-flop synchronizer (sync0 -> sync1) before any other logic uses it.
REQ-011 A stability counter of width $clog2(STABLE_CYCLES+1) SHALL clear to 0 on any cycle where sync1 == btn_level.
REQ-012 While sync1 != btn_level and the counter < STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 When sync1 != btn_level and the counter == STABLE_CYCLES-1, at that edge: btn_level <= sync1; counter <= 0; and rise_pulse or fall_pulse is asserted according to direction.
REQ-014 Latency: if btn_in is first sampled at a new stable value on edge 1, btn_level SHALL change on edge STABLE_CYCLES+2 and not earlier.
REQ-015 Any excursion of sync1 lasting fewer than STABLE_CYCLES consecutive cycles SHALL leave btn_level, the pulses, and press_count unchanged.
REQ-016 If sync1 returns to btn_level on the same edge where the counter == STABLE_CYCLES-1, there is no update and the counter clears.
REQ-017 rise_pulse and fall_pulse SHALL be mutually exclusive and never high for two consecutive cycles.
REQ-018 press_count SHALL increment by 1 in the same edge that asserts rise_pulse, and SHALL wrap from 2^CNT_W-1 to 0 without flagging.
REQ-019 The counter SHALL never exceed STABLE_CYCLES-1, and SHALL never wrap.

Reset
REQ-020 With rst high at a clk edge, sync0, sync1, btn_level, the counter, rise_pulse, fall_pulse and press_count SHALL all load 0.
REQ-021 Reset asserted mid-count SHALL discard the partial count; after deassertion, a full STABLE_CYCLES+2 latency applies again.
REQ-022 Reset SHALL take precedence over every other update in the same cycle, including a pending REQ-013 update.

Structure
REQ-023 The default STABLE_CYCLES value and the counter-width computation SHALL live in a shared package, debounce_pkg.
REQ-024 The two-flop synchronizer SHALL be a separate sub-module, sync_2ff, with ports clk, rst, d and q, and reset value 0.
REQ-025 All outputs SHALL be driven directly from flops, with no combinational path from btn_in to any output.

Verification (STABLE_CYCLES=4, CNT_W=8)
REQ-026 Reset: hold rst=1 for 3 cycles with btn_in=1 -> all outputs are 0; after release, btn_level rises on the 6th edge and rise_pulse is high for exactly that one cycle.
REQ-027 Clean press: btn_in 0->1 held -> btn_level=1 at edge 6, rise_pulse one cycle, press_count=1; release held -> btn_level=0 at edge 6, fall_pulse one cycle.
REQ-028 Bounce: btn_in toggles 1,0,1,0,1 with each value held 3 cycles, then held at 1 -> exactly one rise_pulse, occurring 6 edges after the final 0->1, with press_count +1.
REQ-029 Boundary glitch: btn_in held high for exactly 3 sampled cycles, then low -> btn_level stays 0 and no pulse fires; held for exactly 4 -> btn_level rises.
REQ-030 Reset mid-count: assert rst on the 3rd counting cycle -> no pulse fires and counting restarts from 0 after release.
REQ-031 Wrap: 256 debounced presses -> press_count returns to 0 and exactly 256 rise_pulses are counted.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared constants and helpers for the push-button debouncer.
// The default settle time suits a 50 MHz clock with a 10 ms bounce window.
package debounce_pkg;

    // Consecutive stable cycles required before the debounced level follows the input.
    localparam int DEFAULT_STABLE_CYCLES = 500000;

    // Default width of the debounced press counter.
    localparam int DEFAULT_CNT_W = 8;

    // Classifies what the debouncer did on a given edge.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edgeKind_e;

    // Width of the stability counter.
    // It only counts up to stableCycles-1, so stableCycles+1 distinct
    // values always fit and the counter can never wrap.
    function automatic int stableCntWidth(input int stableCycles);
        return $clog2(stableCycles + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer that brings the raw, asynchronous button input into
// the clk domain. Nothing else may look at the raw input before it has
// passed through both flops.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_sync0;
    logic r_sync1;

    // Shift the raw input through two flops; reset clears both to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= d;
            r_sync1 <= r_sync0;
        end
    end

    assign q = r_sync1;

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce
// Debounces a mechanical push button. The synchronized input has to disagree
// with the current debounced level for STABLE_CYCLES consecutive cycles
// before the level follows it. Every accepted transition produces a
// one-cycle rise or fall pulse, and rising transitions are counted
// (wrapping) in press_count. All outputs come straight from flops.
module btn_debounce
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    output logic             btn_level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int STAB_W = stableCntWidth(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic              w_sync;
    logic              w_differs;
    logic              w_expired;
    edgeKind_e         w_edgeKind;

    logic [STAB_W-1:0] r_stableCnt;
    logic              r_btnLevel;
    logic              r_risePulse;
    logic              r_fallPulse;
    logic [CNT_W-1:0]  r_pressCount;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (w_sync)
    );

    // Decide whether this edge accepts a new level, and in which direction.
    // If the input falls back to the current level on the very edge the
    // count would have expired, w_differs is low and nothing is accepted.
    always_comb begin
        w_differs  = 1'b0;
        w_expired  = 1'b0;
        w_edgeKind = EDGE_NONE;
        w_differs  = (w_sync != r_btnLevel);
        w_expired  = w_differs && (r_stableCnt == STAB_LAST);
        if (w_expired) begin
            w_edgeKind = w_sync ? EDGE_RISE : EDGE_FALL;
        end
    end

    // Stability counter: clears whenever the input agrees with the level,
    // climbs while it disagrees, and restarts after a transition is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stableCnt <= '0;
        end else if (!w_differs || w_expired) begin
            r_stableCnt <= '0;
        end else begin
            r_stableCnt <= r_stableCnt + STAB_ONE;
        end
    end

    // Debounced level, one-cycle edge pulses and the wrapping press counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btnLevel   <= 1'b0;
            r_risePulse  <= 1'b0;
            r_fallPulse  <= 1'b0;
            r_pressCount <= '0;
        end else begin
            r_risePulse <= (w_edgeKind == EDGE_RISE);
            r_fallPulse <= (w_edgeKind == EDGE_FALL);
            if (w_expired) begin
                r_btnLevel <= w_sync;
            end
            if (w_edgeKind == EDGE_RISE) begin
                r_pressCount <= r_pressCount + CNT_ONE;
            end
        end
    end

    assign btn_level   = r_btnLevel;
    assign rise_pulse  = r_risePulse;
    assign fall_pulse  = r_fallPulse;
    assign press_count = r_pressCount;

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce
// Self-checking bench for btn_debounce with STABLE_CYCLES=4, CNT_W=8.
// A behavioural model (sample history plus a run-length rule) predicts every
// output on every cycle; table vectors and hand sequences add fixed expectations.
module tb_btn_debounce;

    localparam int S     = 4;
    localparam int CNT_W = 8;

    typedef struct {
        logic r;
        logic b;
        logic lvl;
        logic rise;
        logic fall;
        int   cnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             btnIn = 1'b0;
    logic             btnLevel;
    logic             risePulse;
    logic             fallPulse;
    logic [CNT_W-1:0] pressCount;

    int checks   = 0;
    int failures = 0;
    int tickNo   = 0;
    int riseCount = 0;
    int fallCount = 0;
    int lastRiseTick = 0;
    logic prevPulse = 1'b0;

    // Reference model state
    logic             hist0 = 1'b0;
    logic             hist1 = 1'b0;
    logic             mLevel = 1'b0;
    logic             mRise = 1'b0;
    logic             mFall = 1'b0;
    int               mRun = 0;
    logic [CNT_W-1:0] mCount = '0;

    vec_t tbl[$];

    btn_debounce #(
        .STABLE_CYCLES (S),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btnIn),
        .btn_level   (btnLevel),
        .rise_pulse  (risePulse),
        .fall_pulse  (fallPulse),
        .press_count (pressCount)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    task automatic checkOne(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at tick %0d: actual=%0d expected=%0d", name, tickNo, actual, expected);
        end
    endtask

    // The debounced level follows the input value seen two samples ago once
    // that value has disagreed with it for S consecutive edges.
    task automatic modelStep(input logic r, input logic b);
        logic seen;
        if (r) begin
            hist0 = 1'b0; hist1 = 1'b0;
            mLevel = 1'b0; mRise = 1'b0; mFall = 1'b0;
            mRun = 0; mCount = '0;
            return;
        end
        seen  = hist1;
        mRise = 1'b0;
        mFall = 1'b0;
        if (seen != mLevel) begin
            mRun++;
            if (mRun == S) begin
                mLevel = seen;
                mRun   = 0;
                mRise  = seen;
                mFall  = !seen;
                if (seen) mCount = mCount + 1'b1;
            end
        end else begin
            mRun = 0;
        end
        hist1 = hist0;
        hist0 = b;
    endtask

    task automatic checkOutput();
        checkOne("btn_level", btnLevel, mLevel);
        checkOne("rise_pulse", risePulse, mRise);
        checkOne("fall_pulse", fallPulse, mFall);
        checkOne("press_count", pressCount, mCount);
        checkOne("pulse_exclusive", risePulse & fallPulse, 0);
        checkOne("pulse_not_back_to_back", prevPulse & (risePulse | fallPulse), 0);
        prevPulse = risePulse | fallPulse;
        if (risePulse) begin
            riseCount++;
            lastRiseTick = tickNo;
        end
        if (fallPulse) fallCount++;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check 1 unit later
    task automatic applyStimulus(input logic r, input logic b);
        rst   = r;
        btnIn = b;
        @(posedge clk);
        tickNo++;
        modelStep(r, b);
        #1;
        checkOutput();
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, b);
    endtask

    initial begin
        int   startTick;
        int   baseRise;
        int   baseFall;
        logic pat [5];
        logic v;
        int   len;

        // Table: reset with button held high, then clean press and release
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0});
        for (int i = 0; i < 7; i++)
            tbl.push_back('{1'b0, 1'b1, (i >= 5), (i == 5), 1'b0, (i >= 5) ? 1 : 0});
        for (int i = 0; i < 7; i++)
            tbl.push_back('{1'b0, 1'b0, (i < 5), 1'b0, (i == 5), 1});

        #2;
        foreach (tbl[k]) begin
            applyStimulus(tbl[k].r, tbl[k].b);
            checkOne("tbl_level", btnLevel, tbl[k].lvl);
            checkOne("tbl_rise", risePulse, tbl[k].rise);
            checkOne("tbl_fall", fallPulse, tbl[k].fall);
            checkOne("tbl_count", pressCount, tbl[k].cnt);
        end

        // Bounce 1,0,1,0,1 (3 cycles each) then hold 1: single rise 6 edges after final 0->1
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1;
        startTick = tickNo;
        baseRise  = riseCount;
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, (i < 15) ? pat[i / 3] : 1'b1);
        checkOne("bounce_rise_count", riseCount - baseRise, 1);
        checkOne("bounce_rise_edge", lastRiseTick - startTick, 18);
        checkOne("bounce_press_count", pressCount, 2);
        hold(1'b0, 10);
        checkOne("bounce_release_level", btnLevel, 0);

        // Glitch of 3 sampled cycles is rejected
        baseRise = riseCount;
        baseFall = fallCount;
        hold(1'b1, 3);
        hold(1'b0, 10);
        checkOne("glitch3_rise", riseCount - baseRise, 0);
        checkOne("glitch3_fall", fallCount - baseFall, 0);
        checkOne("glitch3_level", btnLevel, 0);

        // Pulse of exactly 4 sampled cycles is accepted
        startTick = tickNo;
        baseRise  = riseCount;
        hold(1'b1, 4);
        hold(1'b0, 10);
        checkOne("glitch4_rise", riseCount - baseRise, 1);
        checkOne("glitch4_rise_edge", lastRiseTick - startTick, 6);
        checkOne("glitch4_press_count", pressCount, 3);

        // Reset on the 3rd counting edge discards the partial count
        baseRise = riseCount;
        hold(1'b1, 4);
        applyStimulus(1'b1, 1'b1);
        checkOne("midreset_no_rise", riseCount - baseRise, 0);
        checkOne("midreset_count_cleared", pressCount, 0);
        startTick = tickNo;
        hold(1'b1, 10);
        checkOne("midreset_rise", riseCount - baseRise, 1);
        checkOne("midreset_rise_edge", lastRiseTick - startTick, 6);
        checkOne("midreset_press_count", pressCount, 1);
        hold(1'b0, 10);

        // Random runs with occasional resets, checked cycle by cycle against the model
        for (int i = 0; i < 600; i++) begin
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            if ($urandom_range(0, 49) == 0) applyStimulus(1'b1, v);
            hold(v, len);
        end

        // 256 debounced presses wrap press_count back to 0
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        baseRise = riseCount;
        for (int i = 0; i < 256; i++) begin
            hold(1'b1, 7);
            hold(1'b0, 7);
        end
        checkOne("wrap_rise_count", riseCount - baseRise, 256);
        checkOne("wrap_press_count", pressCount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
